// File: rtl/multiplexer_rr_pkg.sv
// Shared defaults and types for the round-robin registered multiplexer.
package multiplexer_rr_pkg;

  localparam int unsigned MUX_DATA_WIDTH = 32;
  localparam int unsigned MUX_NUM_INPUTS = 4;
  localparam int unsigned MUX_SEL_WIDTH  = 2;

  // Grant-lock state: OPEN arbitrates freely, HELD pins the grant to lock_ch.
  typedef enum logic {
    LOCK_OPEN = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  // Index width needed to address n channels, never below 1.
  function automatic int unsigned sel_width_for(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/multiplexer_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past last_grant and wraps.
module rr_arbiter
  import multiplexer_rr_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = MUX_NUM_INPUTS,
  parameter int unsigned SEL_WIDTH  = MUX_SEL_WIDTH
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [SEL_WIDTH-1:0]  last_grant,
  output logic [SEL_WIDTH-1:0]  grant_c,
  output logic                  grant_valid_c
);

  localparam int unsigned SW1 = SEL_WIDTH + 1;

  logic [SEL_WIDTH-1:0]    start;
  logic [SEL_WIDTH-1:0]    offset;
  logic [2*NUM_INPUTS-1:0] dbl;
  logic [NUM_INPUTS-1:0]   rot;
  logic [SW1-1:0]          sum;

  // Rotate the doubled request vector so the start channel lands at bit 0,
  // priority-encode the lowest set bit, then rotate the index back.
  always_comb begin
    start         = (last_grant == SEL_WIDTH'(NUM_INPUTS - 1)) ? '0
                                                               : last_grant + SEL_WIDTH'(1);
    dbl           = {req, req};
    rot           = NUM_INPUTS'(dbl >> start);
    offset        = '0;
    grant_valid_c = 1'b0;
    for (int i = int'(NUM_INPUTS) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        offset        = SEL_WIDTH'(i);
        grant_valid_c = 1'b1;
      end
    end
    sum = {1'b0, start} + {1'b0, offset};
    if (sum >= SW1'(NUM_INPUTS)) sum = sum - SW1'(NUM_INPUTS);
    grant_c = sum[SEL_WIDTH-1:0];
  end

endmodule

// File: rtl/multiplexer_rr.sv
// N-input registered multiplexer with valid/ready handshake, round-robin
// arbitration and grant locking for multi-beat transfers.
module multiplexer_rr
  import multiplexer_rr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MUX_DATA_WIDTH,
  parameter int unsigned NUM_INPUTS = MUX_NUM_INPUTS,
  parameter int unsigned SEL_WIDTH  = MUX_SEL_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS-1:0]            in_lock,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [SEL_WIDTH-1:0]             out_sel,
  output logic                             out_valid,
  input  logic                             out_ready
);

`ifdef SIMULATION
  if (SEL_WIDTH != sel_width_for(NUM_INPUTS)) begin : g_sel_width_chk
    $error("multiplexer_rr: SEL_WIDTH does not match NUM_INPUTS");
  end
`endif

  lock_state_e          state_q, state_d;
  logic [SEL_WIDTH-1:0] lock_ch_q, lock_ch_d;
  logic [SEL_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] out_data_d;
  logic [SEL_WIDTH-1:0] out_sel_d;
  logic                 out_valid_d;

  logic                 load_en_c;
  logic                 accept_c;
  logic [SEL_WIDTH-1:0] arb_grant_c;
  logic                 arb_valid_c;
  logic [SEL_WIDTH-1:0] grant_c;
  logic                 grant_ok_c;

  logic [DATA_WIDTH-1:0] chan [NUM_INPUTS];

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
    assign chan[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_arb (
    .req           (in_valid),
    .last_grant    (last_grant_q),
    .grant_c       (arb_grant_c),
    .grant_valid_c (arb_valid_c)
  );

  // Next-state: a held lock pins the grant even while the owner is idle.
  always_comb begin
    state_d      = state_q;
    lock_ch_d    = lock_ch_q;
    last_grant_d = last_grant_q;
    out_data_d   = out_data;
    out_sel_d    = out_sel;
    out_valid_d  = out_valid;
    in_ready     = '0;
    load_en_c    = !out_valid || out_ready;
    grant_c      = arb_grant_c;
    grant_ok_c   = arb_valid_c;

    if (state_q == LOCK_HELD) begin
      grant_c    = lock_ch_q;
      grant_ok_c = in_valid[lock_ch_q];
    end

    accept_c = load_en_c && grant_ok_c && !rst;

    if (accept_c) begin
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
        in_ready[i] = (grant_c == SEL_WIDTH'(i));
      end
      out_data_d   = chan[grant_c];
      out_sel_d    = grant_c;
      out_valid_d  = 1'b1;
      last_grant_d = grant_c;
      lock_ch_d    = grant_c;
      state_d      = in_lock[grant_c] ? LOCK_HELD : LOCK_OPEN;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOCK_OPEN;
      lock_ch_q    <= '0;
      last_grant_q <= SEL_WIDTH'(NUM_INPUTS - 1);
      out_data     <= '0;
      out_sel      <= '0;
      out_valid    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_ch_q    <= lock_ch_d;
      last_grant_q <= last_grant_d;
      out_data     <= out_data_d;
      out_sel      <= out_sel_d;
      out_valid    <= out_valid_d;
    end
  end

endmodule
